// File: rtl/sprite_pkg.sv
// Shared types for the sprite palette writer: RGB444 pixel type and writer FSM states.
package sprite_pkg;

  localparam int RGB444_W = 12;

  typedef logic [RGB444_W-1:0] rgb444_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } writer_state_t;

endpackage

// File: rtl/sprite_palette_writer_if.sv
// Raster-order RGB444 pixel stream with valid/ready handshake.
// The producer side uses the master modport, the palette writer the slave modport.
interface sprite_palette_writer_if;
  import sprite_pkg::*;

  rgb444_t pixel_in;
  logic    pixel_valid_in;
  logic    pixel_ready_out;

  modport master (
    output pixel_in,
    output pixel_valid_in,
    input  pixel_ready_out
  );

  modport slave (
    input  pixel_in,
    input  pixel_valid_in,
    output pixel_ready_out
  );

endinterface

// File: rtl/sprite_palette_writer_match.sv
// palette_match: compares one pixel against every valid palette entry in parallel
// and reports the lowest matching index.
module palette_match
  import sprite_pkg::*;
#(
  parameter int PALETTE_DEPTH = 16
) (
  input  rgb444_t                      pixel_in,
  input  rgb444_t [PALETTE_DEPTH-1:0]  colors_in,
  input  logic    [PALETTE_DEPTH-1:0]  valid_in,
  output logic                         hit_out,
  output logic    [7:0]                index_out
);

  // Priority encode the comparator hits; scanning downwards lets the lowest index win.
  always_comb begin
    hit_out   = 1'b0;
    index_out = 8'd0;
    for (int i = PALETTE_DEPTH - 1; i >= 0; i--) begin
      if (valid_in[i] && (colors_in[i] == pixel_in)) begin
        hit_out   = 1'b1;
        index_out = 8'(i);
      end
    end
  end

endmodule

// File: rtl/sprite_palette_writer.sv
// sprite_palette_writer: encodes a raster RGB444 pixel stream into palette indices,
// emitting image RAM writes (one per pixel) and palette RAM writes (one per new colour).
// Optional feature macro: SPRITE_WRITER_TRANSP_EN reserves index 0 for TRANSP_COLOR
// at the start of every frame.
module sprite_palette_writer
  import sprite_pkg::*;
#(
  parameter int      WIDTH         = 900,
  parameter int      HEIGHT        = 24,
  parameter int      PALETTE_DEPTH = 16,
  parameter rgb444_t TRANSP_COLOR  = 12'h000,
  localparam int     ADDR_W        = $clog2(WIDTH * HEIGHT)
) (
  input  logic                     pixel_clk_in,
  input  logic                     rst_n_in,
  input  logic                     start_in,
  sprite_palette_writer_if.slave   pix,
  output logic                     image_we_out,
  output logic [ADDR_W-1:0]        image_addr_out,
  output logic [7:0]               image_data_out,
  output logic                     palette_we_out,
  output logic [7:0]               palette_addr_out,
  output rgb444_t                  palette_data_out,
  output logic [8:0]               palette_count_out,
  output logic                     busy_out,
  output logic                     done_out,
  output logic                     overflow_out
);

`ifdef SPRITE_WRITER_TRANSP_EN
  localparam bit TRANSP_EN = 1'b1;
`else
  localparam bit TRANSP_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST_PIX_C  = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [8:0]        PAL_DEPTH_C = 9'(PALETTE_DEPTH);

  writer_state_t state_q, state_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [8:0]        pal_cnt_q, pal_cnt_d;
  logic              overflow_q, overflow_d;
  // High for the first WRITE cycle while the reserved transparent entry is published.
  logic              init_q, init_d;

  rgb444_t [PALETTE_DEPTH-1:0] tbl_color_q, tbl_color_d;
  logic    [PALETTE_DEPTH-1:0] tbl_valid_q, tbl_valid_d;

  logic              image_we_q, image_we_d;
  logic [ADDR_W-1:0] image_addr_q, image_addr_d;
  logic [7:0]        image_data_q, image_data_d;
  logic              palette_we_q, palette_we_d;
  logic [7:0]        palette_addr_q, palette_addr_d;
  rgb444_t           palette_data_q, palette_data_d;

  logic       match_hit;
  logic [7:0] match_idx;
  logic       xfer;
  logic [7:0] alloc_idx;

  palette_match #(
    .PALETTE_DEPTH (PALETTE_DEPTH)
  ) u_match (
    .pixel_in  (pix.pixel_in),
    .colors_in (tbl_color_q),
    .valid_in  (tbl_valid_q),
    .hit_out   (match_hit),
    .index_out (match_idx)
  );

  assign pix.pixel_ready_out = (state_q == WRITE) && !init_q;
  assign xfer                = pix.pixel_ready_out && pix.pixel_valid_in;
  assign alloc_idx           = pal_cnt_q[7:0];

  assign busy_out          = (state_q == WRITE) || (state_q == DONE);
  assign done_out          = (state_q == DONE);
  assign image_we_out      = image_we_q;
  assign image_addr_out    = image_addr_q;
  assign image_data_out    = image_data_q;
  assign palette_we_out    = palette_we_q;
  assign palette_addr_out  = palette_addr_q;
  assign palette_data_out  = palette_data_q;
  assign palette_count_out = pal_cnt_q;
  assign overflow_out      = overflow_q;

  // Next-state: FSM transitions, pixel encoding, palette allocation and write strobes.
  always_comb begin
    state_d        = state_q;
    pix_cnt_d      = pix_cnt_q;
    pal_cnt_d      = pal_cnt_q;
    overflow_d     = overflow_q;
    init_d         = 1'b0;
    tbl_color_d    = tbl_color_q;
    tbl_valid_d    = tbl_valid_q;
    image_we_d     = 1'b0;
    image_addr_d   = image_addr_q;
    image_data_d   = image_data_q;
    palette_we_d   = 1'b0;
    palette_addr_d = palette_addr_q;
    palette_data_d = palette_data_q;

    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d     = WRITE;
          pix_cnt_d   = '0;
          pal_cnt_d   = 9'd0;
          overflow_d  = 1'b0;
          tbl_valid_d = '0;
          if (TRANSP_EN) begin
            // Entry 0 is pre-loaded so the palette write lands in the first WRITE cycle.
            tbl_color_d[0] = TRANSP_COLOR;
            tbl_valid_d[0] = 1'b1;
            pal_cnt_d      = 9'd1;
            palette_we_d   = 1'b1;
            palette_addr_d = 8'd0;
            palette_data_d = TRANSP_COLOR;
            init_d         = 1'b1;
          end
        end
      end

      WRITE: begin
        if (xfer) begin
          image_we_d   = 1'b1;
          image_addr_d = pix_cnt_q;
          if (match_hit) begin
            image_data_d = match_idx;
          end else if (pal_cnt_q < PAL_DEPTH_C) begin
            // New colour: the table entry is live from the next edge, so an
            // immediate repeat of this colour already hits.
            image_data_d = alloc_idx;
            for (int i = 0; i < PALETTE_DEPTH; i++) begin
              if (8'(i) == alloc_idx) begin
                tbl_color_d[i] = pix.pixel_in;
                tbl_valid_d[i] = 1'b1;
              end
            end
            palette_we_d   = 1'b1;
            palette_addr_d = alloc_idx;
            palette_data_d = pix.pixel_in;
            pal_cnt_d      = pal_cnt_q + 9'd1;
          end else begin
            // Palette full: fall back to index 0 and flag the loss of colour.
            image_data_d = 8'd0;
            overflow_d   = 1'b1;
          end

          if (pix_cnt_q == LAST_PIX_C) begin
            state_d = DONE;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q        <= IDLE;
      pix_cnt_q      <= '0;
      pal_cnt_q      <= 9'd0;
      overflow_q     <= 1'b0;
      init_q         <= 1'b0;
      tbl_color_q    <= '0;
      tbl_valid_q    <= '0;
      image_we_q     <= 1'b0;
      image_addr_q   <= '0;
      image_data_q   <= 8'd0;
      palette_we_q   <= 1'b0;
      palette_addr_q <= 8'd0;
      palette_data_q <= '0;
    end else begin
      state_q        <= state_d;
      pix_cnt_q      <= pix_cnt_d;
      pal_cnt_q      <= pal_cnt_d;
      overflow_q     <= overflow_d;
      init_q         <= init_d;
      tbl_color_q    <= tbl_color_d;
      tbl_valid_q    <= tbl_valid_d;
      image_we_q     <= image_we_d;
      image_addr_q   <= image_addr_d;
      image_data_q   <= image_data_d;
      palette_we_q   <= palette_we_d;
      palette_addr_q <= palette_addr_d;
      palette_data_q <= palette_data_d;
    end
  end

endmodule

// File: tb/tb_sprite_palette_writer.sv
// Testbench for sprite_palette_writer with a 2x2 sprite and a 2-entry palette.
module tb_sprite_palette_writer;
  import sprite_pkg::*;

  localparam int W = 2;
  localparam int H = 2;
  localparam int D = 2;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;

  logic        image_we;
  logic [1:0]  image_addr;
  logic [7:0]  image_data;
  logic        palette_we;
  logic [7:0]  palette_addr;
  rgb444_t     palette_data;
  logic [8:0]  palette_count;
  logic        busy;
  logic        done;
  logic        overflow;

  int tests = 0;
  int fails = 0;
  int img_writes = 0;
  int done_cnt = 0;

  wr_t img_q[$];
  wr_t pal_q[$];

  rgb444_t m_col[D];
  int      m_cnt;
  int      m_pix;
  bit      m_ovf;

  always #5 clk = ~clk;

  sprite_palette_writer_if pif();

  sprite_palette_writer #(
    .WIDTH         (W),
    .HEIGHT        (H),
    .PALETTE_DEPTH (D),
    .TRANSP_COLOR  (12'h000)
  ) dut (
    .pixel_clk_in      (clk),
    .rst_n_in          (rst_n),
    .start_in          (start),
    .pix               (pif),
    .image_we_out      (image_we),
    .image_addr_out    (image_addr),
    .image_data_out    (image_data),
    .palette_we_out    (palette_we),
    .palette_addr_out  (palette_addr),
    .palette_data_out  (palette_data),
    .palette_count_out (palette_count),
    .busy_out          (busy),
    .done_out          (done),
    .overflow_out      (overflow)
  );

  // Scoreboard: every RAM write strobe must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      if (image_we) begin
        img_writes++;
        tests++;
        if (img_q.size() == 0) begin
          fails++;
          $display("FAIL image_write_unexpected addr=%0d data=%0d", image_addr, image_data);
        end else begin
          e = img_q.pop_front();
          if (int'(image_addr) !== e.addr || int'(image_data) !== e.data) begin
            fails++;
            $display("FAIL image_write got addr=%0d data=%0d expected addr=%0d data=%0d",
                     image_addr, image_data, e.addr, e.data);
          end
        end
      end
      if (palette_we) begin
        tests++;
        if (pal_q.size() == 0) begin
          fails++;
          $display("FAIL palette_write_unexpected addr=%0d data=%h", palette_addr, palette_data);
        end else begin
          e = pal_q.pop_front();
          if (int'(palette_addr) !== e.addr || int'(palette_data) !== e.data) begin
            fails++;
            $display("FAIL palette_write got addr=%0d data=%h expected addr=%0d data=%h",
                     palette_addr, palette_data, e.addr, e.data);
          end
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic model_start();
    m_cnt = 0;
    m_pix = 0;
    m_ovf = 1'b0;
`ifdef SPRITE_WRITER_TRANSP_EN
    m_col[0] = 12'h000;
    m_cnt = 1;
    pal_q.push_back('{addr: 0, data: 0});
`endif
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    model_start();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send(input rgb444_t p);
    int  n;
    int  idx;
    bit  hit;
    pif.pixel_in = p;
    pif.pixel_valid_in = 1'b1;
    n = 0;
    @(negedge clk);
    while (!pif.pixel_ready_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!pif.pixel_ready_out) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout got ready=0 expected ready=1 within 20 cycles");
      pif.pixel_valid_in = 1'b0;
      return;
    end
    hit = 1'b0;
    idx = 0;
    for (int i = 0; i < m_cnt; i++) begin
      if (!hit && m_col[i] == p) begin
        hit = 1'b1;
        idx = i;
      end
    end
    if (!hit) begin
      if (m_cnt < D) begin
        idx = m_cnt;
        m_col[m_cnt] = p;
        pal_q.push_back('{addr: m_cnt, data: int'(p)});
        m_cnt++;
      end else begin
        idx = 0;
        m_ovf = 1'b1;
      end
    end
    img_q.push_back('{addr: m_pix, data: idx});
    m_pix++;
    @(posedge clk);
    #1;
    pif.pixel_valid_in = 1'b0;
  endtask

  task automatic idle_cycle();
    pif.pixel_valid_in = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic finish_frame(input string name);
    int n;
    n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL %s_done got %b expected 1", name, done);
    end
    @(posedge clk);
    #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_done_pulse got done=%b busy=%b expected done=0 busy=0", name, done, busy);
    end
    tests++;
    if (img_q.size() != 0 || pal_q.size() != 0) begin
      fails++;
      $display("FAIL %s_missing_writes got pending img=%0d pal=%0d expected 0", name,
               img_q.size(), pal_q.size());
    end
    tests++;
    if (int'(palette_count) !== m_cnt || overflow !== m_ovf) begin
      fails++;
      $display("FAIL %s_count got count=%0d ovf=%b expected count=%0d ovf=%b", name,
               palette_count, overflow, m_cnt, m_ovf);
    end
  endtask

  task automatic check_all_zero(input string name);
    tests++;
    if ({image_we, image_addr, image_data, palette_we, palette_addr, palette_data,
         palette_count, busy, done, overflow, pif.pixel_ready_out} !== '0) begin
      fails++;
      $display("FAIL %s got we=%b addr=%0d data=%0d pwe=%b paddr=%0d pdata=%h cnt=%0d busy=%b done=%b ovf=%b rdy=%b expected all 0",
               name, image_we, image_addr, image_data, palette_we, palette_addr, palette_data,
               palette_count, busy, done, overflow, pif.pixel_ready_out);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || pif.pixel_ready_out !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset got busy=%b ready=%b expected 0 0", busy, pif.pixel_ready_out);
    end
  endtask

  task automatic test_basic();
    do_start();
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_busy got %b expected 1", busy);
    end
    send(12'hF00);
    send(12'hF00);
    send(12'h0F0);
    send(12'hF00);
    finish_frame("basic");
  endtask

  task automatic test_overflow();
    do_start();
    send(12'hF00);
    send(12'h0F0);
    send(12'h00F);
    send(12'hF00);
    finish_frame("overflow");
    tests++;
    if (overflow !== 1'b1 || palette_count !== 9'd2) begin
      fails++;
      $display("FAIL overflow_sticky got ovf=%b cnt=%0d expected ovf=1 cnt=2", overflow, palette_count);
    end
    do_start();
    tests++;
    if (overflow !== 1'b0 || int'(palette_count) !== m_cnt) begin
      fails++;
      $display("FAIL overflow_clear got ovf=%b cnt=%0d expected ovf=0 cnt=%0d", overflow,
               palette_count, m_cnt);
    end
    send(12'h00F);
    send(12'h00F);
    send(12'h00F);
    send(12'h00F);
    finish_frame("overflow_next");
  endtask

  task automatic test_stall();
    int w0;
    bit pattern[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    rgb444_t px[4] = '{12'h0F0, 12'h123, 12'h0F0, 12'h123};
    int k;
    w0 = img_writes;
    do_start();
    k = 0;
    for (int i = 0; i < 6; i++) begin
      if (pattern[i]) begin
        send(px[k]);
        k++;
      end else begin
        idle_cycle();
      end
    end
    finish_frame("stall");
    tests++;
    if (img_writes - w0 !== 4) begin
      fails++;
      $display("FAIL stall_write_count got %0d expected 4", img_writes - w0);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_start();
    send(12'hABC);
    send(12'hDEF);
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid_frame");
    img_q.delete();
    pal_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_mid_frame_hold");
    @(negedge clk);
    rst_n = 1'b1;
    do_start();
    tests++;
    if (palette_count !== 9'(m_cnt)) begin
      fails++;
      $display("FAIL restart_count got %0d expected %0d", palette_count, m_cnt);
    end
    send(12'hDEF);
    send(12'hABC);
    send(12'hDEF);
    send(12'hABC);
    finish_frame("restart");
  endtask

  task automatic test_start_ignored();
    int d0;
    d0 = done_cnt;
    do_start();
    send(12'h111);
    send(12'h222);
    start = 1'b1;
    send(12'h111);
    start = 1'b0;
    send(12'h222);
    finish_frame("start_ignored");
    repeat (4) idle_cycle();
    tests++;
    if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL start_ignored_done got done_pulses=%0d busy=%b expected 1 0", done_cnt - d0, busy);
    end
  endtask

`ifdef SPRITE_WRITER_TRANSP_EN
  task automatic test_transparent();
    do_start();
    tests++;
    if (pif.pixel_ready_out !== 1'b0 || palette_we !== 1'b1) begin
      fails++;
      $display("FAIL transp_first_cycle got ready=%b pwe=%b expected 0 1", pif.pixel_ready_out, palette_we);
    end
    send(12'h000);
    send(12'hF00);
    send(12'hF00);
    send(12'h0F0);
    finish_frame("transparent");
  endtask
`endif

  initial begin
    pif.pixel_in = '0;
    pif.pixel_valid_in = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_stall();
    test_reset_mid_frame();
    test_start_ignored();
`ifdef SPRITE_WRITER_TRANSP_EN
    test_transparent();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
